// File: rtl/ex_alu_pkg.sv
// Shared constants for the execute-stage ALU cluster and branch forwarding.
// Optional feature macro used by the cluster: ALU_SHIFT_EN (SLL/SRL decode).
package ex_alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SLL = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOR = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/ex_alu_bfwd_branch_fwd.sv
// Branch-comparand forward select for one BEQ source register in ID.
// The nearer producer (EX/MEM) wins over MEM/WB; $zero is never forwarded.
module ex_alu_bfwd_branch_fwd
  import ex_alu_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              is_beq,
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_wr,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_wr,
  output logic [1:0]        sel
);

  // Priority select: EX/MEM first, then MEM/WB, else register file.
  always_comb begin
    sel = FWD_RF;
    if (is_beq && (src != '0)) begin
      if (exmem_wr && (exmem_rd == src))
        sel = FWD_EXMEM;
      else if (memwb_wr && (memwb_rd == src))
        sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/ex_alu_bfwd.sv
// Execute-stage ALU cluster: opcode/funct decode, 32-bit ALU, EX/MEM result
// register, and BEQ comparand forward selects for the ID stage.
// Optional macro ALU_SHIFT_EN adds SLL (funct 0x00) and SRL (funct 0x02).
module ex_alu_bfwd
  import ex_alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              hold,
  input  logic [5:0]        ex_op,
  input  logic [5:0]        ex_funct,
  input  logic [4:0]        ex_shamt,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [2:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_result,
  output logic              alu_zero,
  output logic [DATA_W-1:0] result_q,
  output logic              zero_q,
  input  logic [5:0]        id_op,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_wr,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_wr,
  output logic [1:0]        bfwd_a,
  output logic [1:0]        bfwd_b
);

  alu_ctrl_e                 ctrl;
  logic                      is_srl;
  logic signed [DATA_W-1:0]  a_s;
  logic signed [DATA_W-1:0]  b_s;

  assign a_s = $signed(op_a);
  assign b_s = $signed(op_b);

`ifndef ALU_SHIFT_EN
  // Shift amount only matters when the shifter is built in.
  logic unused_shamt;
  assign unused_shamt = ^ex_shamt;
`endif

  // Decode opcode/funct into the 3-bit ALU control (SRL reuses ADD's code).
  always_comb begin
    ctrl   = ALU_ADD;
    is_srl = 1'b0;
    if (ex_op == OP_BEQ) begin
      ctrl = ALU_SUB;
    end else if (ex_op == OP_RTYPE) begin
      case (ex_funct)
        FN_ADD: ctrl = ALU_ADD;
        FN_SUB: ctrl = ALU_SUB;
        FN_AND: ctrl = ALU_AND;
        FN_OR:  ctrl = ALU_OR;
        FN_XOR: ctrl = ALU_XOR;
        FN_NOR: ctrl = ALU_NOR;
        FN_SLT: ctrl = ALU_SLT;
`ifdef ALU_SHIFT_EN
        FN_SLL: ctrl = ALU_SLL;
        FN_SRL: begin
          ctrl   = ALU_ADD;
          is_srl = 1'b1;
        end
`endif
        default: ctrl = ALU_ADD;
      endcase
    end
  end

  assign alu_ctrl = ctrl;

  // ALU datapath; add/sub wrap, SLT compares as signed.
  always_comb begin
    alu_result = op_a + op_b;
    case (ctrl)
      ALU_AND: alu_result = op_a & op_b;
      ALU_OR:  alu_result = op_a | op_b;
      ALU_XOR: alu_result = op_a ^ op_b;
      ALU_NOR: alu_result = ~(op_a | op_b);
      ALU_SUB: alu_result = op_a - op_b;
      ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
`ifdef ALU_SHIFT_EN
      ALU_SLL: alu_result = op_b << ex_shamt;
      ALU_ADD: alu_result = is_srl ? (op_b >> ex_shamt) : (op_a + op_b);
`else
      ALU_ADD: alu_result = op_a + op_b;
`endif
      default: alu_result = op_a + op_b;
    endcase
  end

  assign alu_zero = (alu_result == '0);

  // EX/MEM boundary: capture result and zero flag unless stalled.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else if (!hold) begin
      result_q <= alu_result;
      zero_q   <= alu_zero;
    end
  end

  logic id_is_beq;
  assign id_is_beq = (id_op == OP_BEQ);

  ex_alu_bfwd_branch_fwd #(.REG_AW(REG_AW)) u_fwd_a (
    .is_beq   (id_is_beq),
    .src      (id_rs),
    .exmem_rd (exmem_rd),
    .exmem_wr (exmem_wr),
    .memwb_rd (memwb_rd),
    .memwb_wr (memwb_wr),
    .sel      (bfwd_a)
  );

  ex_alu_bfwd_branch_fwd #(.REG_AW(REG_AW)) u_fwd_b (
    .is_beq   (id_is_beq),
    .src      (id_rt),
    .exmem_rd (exmem_rd),
    .exmem_wr (exmem_wr),
    .memwb_rd (memwb_rd),
    .memwb_wr (memwb_wr),
    .sel      (bfwd_b)
  );

endmodule

// File: tb/tb_ex_alu_bfwd.sv
// Self-checking bench for ex_alu_bfwd: vector tables, randomized ALU and
// forwarding traffic against a reference model, stall and async reset cases.
module tb_ex_alu_bfwd;

  logic        clock;
  logic        rst_n;
  logic        hold;
  logic [5:0]  ex_op;
  logic [5:0]  ex_funct;
  logic [4:0]  ex_shamt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] result_q;
  logic        zero_q;
  logic [5:0]  id_op;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  exmem_rd;
  logic        exmem_wr;
  logic [4:0]  memwb_rd;
  logic        memwb_wr;
  logic [1:0]  bfwd_a;
  logic [1:0]  bfwd_b;

  int checks;
  int failures;

  ex_alu_bfwd #(.DATA_W(32), .REG_AW(5)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .hold       (hold),
    .ex_op      (ex_op),
    .ex_funct   (ex_funct),
    .ex_shamt   (ex_shamt),
    .op_a       (op_a),
    .op_b       (op_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .result_q   (result_q),
    .zero_q     (zero_q),
    .id_op      (id_op),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .exmem_rd   (exmem_rd),
    .exmem_wr   (exmem_wr),
    .memwb_rd   (memwb_rd),
    .memwb_wr   (memwb_wr),
    .bfwd_a     (bfwd_a),
    .bfwd_b     (bfwd_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [31:0] res;
    logic        zero;
  } alu_vec_t;

  typedef struct {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] exrd;
    logic       exwr;
    logic [4:0] mwrd;
    logic       mwwr;
    logic [1:0] sa;
    logic [1:0] sb;
  } fwd_vec_t;

  alu_vec_t av[$];
  fwd_vec_t fv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: ALU control code and result straight from the instruction table.
  task automatic ref_alu(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [2:0] c, output logic [31:0] r);
    c = 3'b010;
    r = a + b;
    if (op == 6'b000100) begin
      c = 3'b110; r = a - b;
    end else if (op == 6'b000000) begin
      if (fn == 6'h22) begin c = 3'b110; r = a - b; end
      else if (fn == 6'h24) begin c = 3'b000; r = a & b; end
      else if (fn == 6'h25) begin c = 3'b001; r = a | b; end
      else if (fn == 6'h26) begin c = 3'b100; r = a ^ b; end
      else if (fn == 6'h27) begin c = 3'b101; r = ~(a | b); end
      else if (fn == 6'h2A) begin c = 3'b111; r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
`ifdef ALU_SHIFT_EN
      else if (fn == 6'h00) begin c = 3'b011; r = b * (32'd1 << sh); end
      else if (fn == 6'h02) begin c = 3'b010; r = b / (32'd1 << sh); end
`endif
    end
    if (sh == 5'd31) r = r; // shamt has no other influence
  endtask

  function automatic logic [1:0] ref_fwd(input logic [5:0] op, input logic [4:0] src,
                                         input logic [4:0] exrd, input logic exwr,
                                         input logic [4:0] mwrd, input logic mwwr);
    if (op != 6'b000100 || src == 5'd0) return 2'd0;
    if (exwr && exrd == src) return 2'd1;
    if (mwwr && mwrd == src) return 2'd2;
    return 2'd0;
  endfunction

  task automatic drive_alu(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                           input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ex_op = op; ex_funct = fn; ex_shamt = sh; op_a = a; op_b = b;
    #1;
  endtask

  task automatic run_alu(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] ec, input logic [31:0] er, input logic ez);
    drive_alu(op, fn, sh, a, b);
    chk({tag, ".ctrl"}, {29'd0, alu_ctrl}, {29'd0, ec});
    chk({tag, ".result"}, alu_result, er);
    chk({tag, ".zero"}, {31'd0, alu_zero}, {31'd0, ez});
    @(posedge clock); #1;
    chk({tag, ".result_q"}, result_q, er);
    chk({tag, ".zero_q"}, {31'd0, zero_q}, {31'd0, ez});
  endtask

  task automatic drive_fwd(input fwd_vec_t v);
    id_op = v.op; id_rs = v.rs; id_rt = v.rt;
    exmem_rd = v.exrd; exmem_wr = v.exwr; memwb_rd = v.mwrd; memwb_wr = v.mwwr;
    #1;
  endtask

  initial begin
    logic [2:0]  ec;
    logic [31:0] er;
    logic [5:0]  ops[10];
    logic [5:0]  fns[11];
    checks = 0;
    failures = 0;

    ops = '{6'h00, 6'h00, 6'h00, 6'b100011, 6'b101011, 6'b001000,
            6'b000100, 6'b000010, 6'b000011, 6'b111111};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h08, 6'h00, 6'h02, 6'h15};

    av.push_back('{6'h00, 6'h20, 5'd0, 32'd7, 32'd5, 3'b010, 32'd12, 1'b0});
    av.push_back('{6'b000100, 6'h00, 5'd0, 32'h1234, 32'h1234, 3'b110, 32'd0, 1'b1});
    av.push_back('{6'h00, 6'h2A, 5'd0, 32'hFFFFFFFF, 32'd1, 3'b111, 32'd1, 1'b0});
    av.push_back('{6'h00, 6'h2A, 5'd0, 32'd1, 32'hFFFFFFFF, 3'b111, 32'd0, 1'b1});
    av.push_back('{6'h00, 6'h24, 5'd0, 32'h0000F0F0, 32'h0000FF00, 3'b000, 32'h0000F000, 1'b0});
    av.push_back('{6'h00, 6'h25, 5'd0, 32'h0000F0F0, 32'h0000FF00, 3'b001, 32'h0000FFF0, 1'b0});
    av.push_back('{6'h00, 6'h26, 5'd0, 32'h0000F0F0, 32'h0000FF00, 3'b100, 32'h00000FF0, 1'b0});
    av.push_back('{6'h00, 6'h27, 5'd0, 32'd0, 32'd0, 3'b101, 32'hFFFFFFFF, 1'b0});
    av.push_back('{6'h00, 6'h22, 5'd0, 32'd0, 32'd1, 3'b110, 32'hFFFFFFFF, 1'b0});
    av.push_back('{6'h00, 6'h20, 5'd0, 32'hFFFFFFFF, 32'd1, 3'b010, 32'd0, 1'b1});
    av.push_back('{6'b100011, 6'h3F, 5'd0, 32'd10, 32'd20, 3'b010, 32'd30, 1'b0});
    av.push_back('{6'b000011, 6'h22, 5'd0, 32'd10, 32'd20, 3'b010, 32'd30, 1'b0});
    av.push_back('{6'h00, 6'h08, 5'd0, 32'd3, 32'd4, 3'b010, 32'd7, 1'b0});
`ifdef ALU_SHIFT_EN
    av.push_back('{6'h00, 6'h00, 5'd4, 32'd3, 32'd1, 3'b011, 32'd16, 1'b0});
    av.push_back('{6'h00, 6'h02, 5'd4, 32'd3, 32'h80000100, 3'b010, 32'h08000010, 1'b0});
    av.push_back('{6'h00, 6'h00, 5'd0, 32'd0, 32'd0, 3'b011, 32'd0, 1'b1});
`else
    av.push_back('{6'h00, 6'h00, 5'd4, 32'd3, 32'd1, 3'b010, 32'd4, 1'b0});
    av.push_back('{6'h00, 6'h02, 5'd4, 32'd3, 32'h80000100, 3'b010, 32'h80000103, 1'b0});
    av.push_back('{6'h00, 6'h00, 5'd0, 32'd0, 32'd0, 3'b010, 32'd0, 1'b1});
`endif

    fv.push_back('{6'b000100, 5'd3, 5'd0, 5'd3, 1'b1, 5'd3, 1'b1, 2'b01, 2'b00});
    fv.push_back('{6'b000100, 5'd3, 5'd0, 5'd3, 1'b0, 5'd3, 1'b1, 2'b10, 2'b00});
    fv.push_back('{6'b000100, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 2'b00});
    fv.push_back('{6'b100011, 5'd3, 5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 2'b00, 2'b00});
    fv.push_back('{6'b000100, 5'd3, 5'd7, 5'd7, 1'b1, 5'd3, 1'b1, 2'b10, 2'b01});
    fv.push_back('{6'b000100, 5'd9, 5'd9, 5'd9, 1'b0, 5'd9, 1'b0, 2'b00, 2'b00});
    fv.push_back('{6'b000100, 5'd31, 5'd31, 5'd30, 1'b1, 5'd31, 1'b1, 2'b10, 2'b10});

    // Reset state, held across one rising edge.
    rst_n = 1'b0; hold = 1'b0;
    ex_op = 6'h00; ex_funct = 6'h20; ex_shamt = 5'd0; op_a = 32'd1; op_b = 32'd2;
    id_op = 6'h00; id_rs = 5'd0; id_rt = 5'd0;
    exmem_rd = 5'd0; exmem_wr = 1'b0; memwb_rd = 5'd0; memwb_wr = 1'b0;
    #7;
    chk("reset.result_q", result_q, 32'd0);
    chk("reset.zero_q", {31'd0, zero_q}, 32'd0);
    @(negedge clock);
    rst_n = 1'b1;

    for (int i = 0; i < av.size(); i++)
      run_alu($sformatf("vec%0d", i), av[i].op, av[i].funct, av[i].shamt,
              av[i].a, av[i].b, av[i].ctrl, av[i].res, av[i].zero);

    for (int i = 0; i < 150; i++) begin
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  sh;
      logic [31:0] a;
      logic [31:0] b;
      op = ops[$urandom_range(0, 9)];
      fn = fns[$urandom_range(0, 10)];
      sh = 5'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      ref_alu(op, fn, sh, a, b, ec, er);
      run_alu($sformatf("rnd%0d", i), op, fn, sh, a, b, ec, er, (er == 32'd0));
    end

    for (int i = 0; i < fv.size(); i++) begin
      drive_fwd(fv[i]);
      chk($sformatf("fwd%0d.a", i), {30'd0, bfwd_a}, {30'd0, fv[i].sa});
      chk($sformatf("fwd%0d.b", i), {30'd0, bfwd_b}, {30'd0, fv[i].sb});
    end

    for (int i = 0; i < 200; i++) begin
      fwd_vec_t v;
      v.op = ($urandom_range(0, 3) != 0) ? 6'b000100 : 6'($urandom);
      v.rs = 5'($urandom_range(0, 3));
      v.rt = 5'($urandom_range(0, 3));
      v.exrd = 5'($urandom_range(0, 3));
      v.exwr = 1'($urandom);
      v.mwrd = 5'($urandom_range(0, 3));
      v.mwwr = 1'($urandom);
      v.sa = ref_fwd(v.op, v.rs, v.exrd, v.exwr, v.mwrd, v.mwwr);
      v.sb = ref_fwd(v.op, v.rt, v.exrd, v.exwr, v.mwrd, v.mwwr);
      drive_fwd(v);
      chk($sformatf("rfwd%0d.a", i), {30'd0, bfwd_a}, {30'd0, v.sa});
      chk($sformatf("rfwd%0d.b", i), {30'd0, bfwd_b}, {30'd0, v.sb});
    end

    // Stall: registered outputs freeze while operands keep moving.
    run_alu("hold.load", 6'h00, 6'h20, 5'd0, 32'd7, 32'd5, 3'b010, 32'd12, 1'b0);
    @(negedge clock);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_alu(6'h00, 6'h22, 5'd0, 32'd50 + 32'(i), 32'd50 + 32'(i));
      @(posedge clock); #1;
      chk($sformatf("hold%0d.result_q", i), result_q, 32'd12);
      chk($sformatf("hold%0d.zero_q", i), {31'd0, zero_q}, 32'd0);
    end
    @(negedge clock);
    hold = 1'b0;
    @(posedge clock); #1;
    chk("unhold.result_q", result_q, 32'd0);
    chk("unhold.zero_q", {31'd0, zero_q}, 32'd1);

    // Asynchronous reset between edges, once with zero_q set, once with a value.
    for (int s = 0; s < 2; s++) begin
      if (s == 0) run_alu("arst0.load", 6'b000100, 6'h00, 5'd0, 32'h55, 32'h55, 3'b110, 32'd0, 1'b1);
      else        run_alu("arst1.load", 6'h00, 6'h25, 5'd0, 32'hA0, 32'h0B, 3'b001, 32'hAB, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk($sformatf("arst%0d.result_q", s), result_q, 32'd0);
      chk($sformatf("arst%0d.zero_q", s), {31'd0, zero_q}, 32'd0);
      chk($sformatf("arst%0d.comb", s), alu_result, (s == 0) ? 32'd0 : 32'hAB);
      @(negedge clock);
      rst_n = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_alu_bfwd.md
Name: ex_alu_bfwd

Overview:
- Execute-stage arithmetic cluster for the 5-stage MIPS pipeline.
- Decodes opcode/funct into a 3-bit ALU control and computes a 32-bit result plus zero flag.
- Registers the result for the EX/MEM boundary.
- Also generates forwarding selects for the two BEQ comparands in ID.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-index width.

Ports:
- clock in 1: rising-edge clock.
- rst_n in 1: asynchronous active-low reset.
- hold in 1: pipeline stall; registered outputs keep their value while high.
- ex_op in 6: ID/EX opcode (IR[31:26]).
- ex_funct in 6: ID/EX funct (IR[5:0]).
- ex_shamt in 5: ID/EX shamt (IR[10:6]).
- op_a in DATA_W: forwarded operand A.
- op_b in DATA_W: forwarded operand B (or immediate).
- alu_ctrl out 3: decoded ALU control (combinational).
- alu_result out DATA_W: combinational result.
- alu_zero out 1: alu_result == 0 (combinational).
- result_q out DATA_W: registered alu_result.
- zero_q out 1: registered alu_zero.
- id_op in 6: IF/ID opcode.
- id_rs in REG_AW: IF/ID rs.
- id_rt in REG_AW: IF/ID rt.
- exmem_rd in REG_AW: EX/MEM destination register.
- exmem_wr in 1: EX/MEM writes a register.
- memwb_rd in REG_AW: MEM/WB destination register.
- memwb_wr in 1: MEM/WB writes a register.
- bfwd_a out 2: BEQ operand-A source select.
- bfwd_b out 2: BEQ operand-B source select.

Behaviour:
- Interface:
  - One clock, named clock.
  - rst_n is asynchronous, active-low.
  - Only result_q and zero_q are state; both reset to 0.
  - All other outputs are combinational and have no reset value.
- Control decode (opcodes):
  - LW 100011, SW 101011, ADDI 001000 -> ADD 010.
  - BEQ 000100 -> SUB 110.
  - J 000010, JAL 000011 -> ADD.
  - Any other opcode -> ADD.
- Control decode (R-type, opcode 000000, by funct):
  - 0x20 -> ADD 010; 0x22 -> SUB 110.
  - 0x24 -> AND 000; 0x25 -> OR 001.
  - 0x26 -> XOR 100; 0x27 -> NOR 101.
  - 0x2A -> SLT 111.
  - 0x08 (JR) -> ADD.
  - Any other funct -> ADD (except as modified under ALU_SHIFT_EN).
- ALU operations:
  - ADD and SUB wrap modulo 2^32; no overflow trap.
  - SLT is a signed compare; result is 1 or 0, zero-extended.
  - Logic ops are bitwise.
- Register update: on each rising clock with hold=0, result_q<=alu_result and zero_q<=alu_zero. With hold=1 both keep their value.
- Branch forward (bfwd_a / bfwd_b):
  - Selects: 00 = register file, 01 = EX/MEM, 10 = MEM/WB; 11 is never produced.
  - Both outputs are 00 unless id_op == BEQ.
  - Operand A: 01 if exmem_wr && exmem_rd == id_rs && id_rs != 0.
  - Otherwise 10 if memwb_wr && memwb_rd == id_rs && id_rs != 0.
  - Otherwise 00.
  - Operand B: same rules using id_rt.
  - EX/MEM wins when both stages match the same source register.
- Reset asserted mid-operation clears result_q/zero_q immediately; combinational paths are unaffected.

Optional Feature:
- Macro: ALU_SHIFT_EN.
- When defined:
  - funct 0x00 -> SLL 011, computing op_b << ex_shamt.
  - funct 0x02 -> SRL, computing logical op_b >> ex_shamt.
  - SRL uses code 010 plus an internal shift qualifier.
  - An all-zero NOP yields 0.
- When undefined:
  - ex_shamt is ignored.
  - funct 0x00 and 0x02 decode as ADD.

Decomposition:
- Package ex_alu_pkg holds:
  - opcode constants (LW, SW, BEQ, ADDI, J, JAL, RTYPE);
  - funct constants;
  - the ALU-control enum (AND, OR, ADD, SUB, XOR, NOR, SLT, SLL);
  - the forward-select constants (FWD_RF, FWD_EXMEM, FWD_MEMWB).
- One natural sub-module: ex_alu_bfwd_branch_fwd, the pure-combinational branch forward logic instantiated twice or once per both operands.
- Decode and ALU stay inline.

Test Plan:
- ex_op=0, funct=0x20, A=7, B=5 -> alu_ctrl=010, alu_result=12; next clock result_q=12.
- ex_op=BEQ, A=B=0x1234 -> alu_ctrl=110, alu_result=0, alu_zero=1.
- funct=0x2A: A=0xFFFFFFFF, B=1 -> result 1; A=1, B=0xFFFFFFFF -> result 0.
- id_op=BEQ, id_rs=3, exmem_rd=3/exmem_wr=1, memwb_rd=3/memwb_wr=1 -> bfwd_a=01.
  - Then with exmem_wr=0 -> bfwd_a=10.
  - id_rs=0 -> 00.
  - id_op=LW -> 00.
- hold=1 with changing operands -> result_q frozen.
  - rst_n low mid-cycle -> result_q=0 and zero_q=0 asynchronously.
- ALU_SHIFT_EN: funct=0x00, shamt=4, B=1 -> 16; without macro same stimulus -> A+B.
